serial_tx_ctrl: RTL and testbench
=================================

SERIAL_TX_CTRL -- requirements
Module: serial_tx_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: clk, reset; reset is synchronous and active-high.
REQ-002 Parameter BIT_CYCLES SHALL default to 4 and set the clk cycles per serial bit; legal range is 1..255.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port reset  input  1  synchronous active-high reset.
REQ-005 Port in_valid  input  1  upstream byte offered.
REQ-006 Port in_data  input  8  upstream byte, sampled only on accept.
REQ-007 Port in_ready  output  1  controller can accept a byte.
REQ-008 Port carga  output  1  parallel-load strobe to the shiftReg datapath.
REQ-009 Port cargaData  output  8  byte presented to shiftReg.
REQ-010 Port shift  output  1  shift-advance strobe to shiftReg.
REQ-011 Port sout  input  1  current MSB from shiftReg.
REQ-012 Port tx  output  1  framed serial line, idle high.
REQ-013 Port busy  output  1  high whenever state is not IDLE.
REQ-014 Port done  output  1  one-cycle pulse at frame end.

Function
REQ-015 Accept SHALL occur on a rising edge where in_valid and in_ready are both high; in_ready SHALL be high only in IDLE.
REQ-016 On accept, in_data SHALL be captured into a hold register driving cargaData; cargaData SHALL NOT change until the next accept.
REQ-017 The FSM SHALL have the states IDLE -> LOAD -> START -> DATA -> STOP -> IDLE, with no other transitions except reset.
REQ-018 LOAD SHALL last exactly 1 cycle, with carga=1; carga SHALL be 0 in every other state.
REQ-019 START SHALL hold tx=0 for BIT_CYCLES cycles.
REQ-020 DATA SHALL hold tx=sout for 8 bit periods of BIT_CYCLES cycles each, MSB first.
REQ-021 shift SHALL be 1 on the last cycle of each DATA bit period (exactly 8 pulses per frame) and 0 otherwise; carga and shift SHALL never both be high.
REQ-022 STOP SHALL hold tx=1 for BIT_CYCLES cycles; done SHALL be 1 on the last STOP cycle, and the next state SHALL be IDLE.
REQ-023 tx SHALL be 1 in IDLE and LOAD; tx SHALL depend only on state and sout, with no combinational path from in_valid or in_data.
REQ-024 Timing: accept at edge k; LOAD is cycle k+1; the first START cycle is k+2; done is in cycle k+1+10*BIT_CYCLES; in_ready SHALL be high the following cycle.
REQ-025 in_valid and in_data changes while busy SHALL be ignored, with no effect on the frame in flight.
REQ-026 The bit-cycle counter SHALL be ceil(log2(BIT_CYCLES)) bits wide (minimum 1); the bit index SHALL be 3 bits and SHALL wrap 7->0 only on the DATA->STOP transition.
REQ-027 With BIT_CYCLES=1, every cycle of DATA SHALL assert shift, and the frame SHALL still be 10 bit periods.

Reset
REQ-028 While reset=1 at an edge, the next state SHALL be IDLE, with outputs in_ready=1, carga=0, shift=0, tx=1, busy=0, done=0, cargaData=8'h00, and all counters cleared.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no done pulse; a byte offered in the same cycle as reset SHALL NOT be accepted.

Structure
REQ-030 Package serial_tx_pkg SHALL hold the state enum, DATA_W=8, and FRAME_BITS=10.
REQ-031 The bit-period counter SHALL be a sub-module bit_timer (inputs: clear, enable; output: period_end); the FSM and hold register SHALL remain in serial_tx_ctrl.
REQ-032 The bench SHALL instantiate serial_tx_ctrl together with shiftReg, with sout looped back.

Verification
REQ-033 Reset: hold reset for 2 cycles -> in_ready=1, tx=1, carga=0, shift=0, busy=0, cargaData=8'h00.
REQ-034 Single byte with BIT_CYCLES=4, in_data=8'hA5 -> carga in cycle k+1; tx bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles; 8 shift pulses; done in cycle k+41.
REQ-035 Back-to-back: in_valid held high with 8'h00 then 8'hFF -> second accept in the cycle after done; tx is 1 for exactly one IDLE cycle plus one LOAD cycle between frames.
REQ-036 Busy ignore: change in_data to 8'h3C during the DATA state of an 8'hC3 frame -> transmitted bits remain 1,1,0,0,0,0,1,1; no accept occurs.
REQ-037 Reset mid-frame: assert reset during data bit 3 -> next cycle tx=1, busy=0, no done; a new byte 8'h81 then transmits correctly.
REQ-038 BIT_CYCLES=1, in_data=8'h81 -> frame takes 10 cycles after LOAD with tx=0,1,0,0,0,0,0,0,1,1; shift is high in all 8 DATA cycles.

Source files
------------

// File: rtl/serial_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_pkg
// Brief    : Shared widths and FSM state encoding for the serial transmitter.
// Revision : 1.0
// ============================================================================
package serial_tx_pkg;

    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : bit_timer
// Brief    : Counts clk cycles within one serial bit period; flags the last.
// Revision : 1.0
// ============================================================================
module bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic period_end
);

    localparam int              CNT_W    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    assign period_end = enable && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            if (period_end) r_cnt <= '0;
            else            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/shiftReg.sv
`default_nettype none
// ============================================================================
// Module   : shiftReg
// Brief    : Parallel-load, MSB-first shift register feeding the transmitter.
// Revision : 1.0
// ============================================================================
module shiftReg
    import serial_tx_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              carga,
    input  logic [DATA_W-1:0] cargaData,
    input  logic              shift,
    output logic              sout
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset)      r_q <= '0;
        else if (carga) r_q <= cargaData;
        else if (shift) r_q <= {r_q[DATA_W-2:0], 1'b0};
    end

    assign sout = r_q[DATA_W-1];

endmodule
`default_nettype wire

// File: rtl/serial_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_ctrl
// Brief    : Frames bytes as start/8 data/stop on tx, driving a shiftReg.
// Revision : 1.0
// ============================================================================
module serial_tx_ctrl
    import serial_tx_pkg::*;
#(
    parameter int BIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              carga,
    output logic [DATA_W-1:0] cargaData,
    output logic              shift,
    input  logic              sout,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_hold;
    logic [2:0]        r_bit_idx;
    logic              w_accept;
    logic              w_tmr_en;
    logic              w_period_end;

    assign w_accept  = in_valid && (r_state == ST_IDLE);
    assign w_tmr_en  = (r_state == ST_START) || (r_state == ST_DATA) || (r_state == ST_STOP);
    assign cargaData = r_hold;
    assign busy      = (r_state != ST_IDLE);

    bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (!w_tmr_en),
        .enable    (w_tmr_en),
        .period_end(w_period_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_hold    <= '0;
            r_bit_idx <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) r_hold <= in_data;
            // Overflow 7->0 coincides with the DATA->STOP transition.
            if ((r_state == ST_DATA) && w_period_end) r_bit_idx <= r_bit_idx + 3'd1;
        end
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        carga    = 1'b0;
        shift    = 1'b0;
        tx       = 1'b1;
        done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                carga  = 1'b1;
                w_next = ST_START;
            end
            ST_START: begin
                tx = 1'b0;
                if (w_period_end) w_next = ST_DATA;
            end
            ST_DATA: begin
                tx    = sout;
                shift = w_period_end;
                if (w_period_end && (r_bit_idx == 3'(DATA_W - 1))) w_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_period_end) begin
                    done   = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_tx_ctrl
// Brief    : Directed bench: controller + shiftReg loopback, BIT_CYCLES 4 and 1.
// Revision : 1.0
// ============================================================================
module tb_serial_tx_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, in_valid_a, in_ready_a, carga_a, shift_a, sout_a, tx_a, busy_a, done_a;
    logic [7:0] in_data_a, cargaData_a;
    logic       reset_b, in_valid_b, in_ready_b, carga_b, shift_b, sout_b, tx_b, busy_b, done_b;
    logic [7:0] in_data_b, cargaData_b;

    int checks   = 0;
    int failures = 0;

    serial_tx_ctrl #(.BIT_CYCLES(4)) dut_a (
        .clk(clk), .reset(reset_a), .in_valid(in_valid_a), .in_data(in_data_a),
        .in_ready(in_ready_a), .carga(carga_a), .cargaData(cargaData_a),
        .shift(shift_a), .sout(sout_a), .tx(tx_a), .busy(busy_a), .done(done_a)
    );
    shiftReg sr_a (
        .clk(clk), .reset(reset_a), .carga(carga_a), .cargaData(cargaData_a),
        .shift(shift_a), .sout(sout_a)
    );

    serial_tx_ctrl #(.BIT_CYCLES(1)) dut_b (
        .clk(clk), .reset(reset_b), .in_valid(in_valid_b), .in_data(in_data_b),
        .in_ready(in_ready_b), .carga(carga_b), .cargaData(cargaData_b),
        .shift(shift_b), .sout(sout_b), .tx(tx_b), .busy(busy_b), .done(done_b)
    );
    shiftReg sr_b (
        .clk(clk), .reset(reset_b), .carga(carga_b), .cargaData(cargaData_b),
        .shift(shift_b), .sout(sout_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered and left in an IDLE cycle; pat[9] is the first bit on the line.
    task automatic frame_a(input logic [7:0] d, input logic [9:0] pat,
                           input logic keep_valid, input logic [7:0] alt);
        int shifts = 0;
        in_valid_a = 1'b1;
        in_data_a  = d;
        chk("pre_ready", in_ready_a, 1);
        chk("pre_tx", tx_a, 1);
        step();
        chk("load_carga", carga_a, 1);
        chk("load_tx", tx_a, 1);
        chk("load_ready", in_ready_a, 0);
        chk("load_busy", busy_a, 1);
        chk("load_shift", shift_a, 0);
        chk("load_cargaData", cargaData_a, d);
        if (!keep_valid) in_valid_a = 1'b0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                if (b == 1 && c == 0) in_data_a = alt;
                chk($sformatf("tx_b%0d_c%0d", b, c), tx_a, pat[9-b]);
                chk($sformatf("shift_b%0d_c%0d", b, c), shift_a, (b >= 1 && b <= 8 && c == 3));
                chk($sformatf("done_b%0d_c%0d", b, c), done_a, (b == 9 && c == 3));
                chk("frame_carga", carga_a, 0);
                chk("frame_ready", in_ready_a, 0);
                chk("frame_busy", busy_a, 1);
                if (shift_a === 1'b1) shifts++;
            end
        end
        chk("hold_data", cargaData_a, d);
        chk("shift_count", shifts, 8);
        step();
        chk("post_ready", in_ready_a, 1);
        chk("post_busy", busy_a, 0);
        chk("post_tx", tx_a, 1);
        chk("post_done", done_a, 0);
    endtask

    initial begin
        reset_a = 1'b1; in_valid_a = 1'b0; in_data_a = 8'h00;
        reset_b = 1'b1; in_valid_b = 1'b0; in_data_b = 8'h00;
        step();
        step();
        chk("rst_ready", in_ready_a, 1);
        chk("rst_tx", tx_a, 1);
        chk("rst_carga", carga_a, 0);
        chk("rst_shift", shift_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_cargaData", cargaData_a, 8'h00);
        chk("rst_b_ready", in_ready_b, 1);
        chk("rst_b_tx", tx_b, 1);
        reset_a = 1'b0;
        reset_b = 1'b0;
        step();

        frame_a(8'hA5, 10'b0101001011, 1'b0, 8'hA5);

        // Back-to-back: valid stays high, exactly one IDLE cycle between frames.
        frame_a(8'h00, 10'b0000000001, 1'b1, 8'hFF);
        frame_a(8'hFF, 10'b0111111111, 1'b0, 8'hFF);

        frame_a(8'hC3, 10'b0110000111, 1'b0, 8'h3C);

        // Abort during data bit 3 of an A5 frame, offering 81 under reset.
        in_valid_a = 1'b1;
        in_data_a  = 8'hA5;
        step();
        in_valid_a = 1'b0;
        for (int i = 0; i < 17; i++) step();
        chk("mid_tx_bit3", tx_a, 0);
        chk("mid_busy", busy_a, 1);
        reset_a    = 1'b1;
        in_valid_a = 1'b1;
        in_data_a  = 8'h81;
        step();
        chk("abort_tx", tx_a, 1);
        chk("abort_busy", busy_a, 0);
        chk("abort_done", done_a, 0);
        chk("abort_ready", in_ready_a, 1);
        chk("abort_cargaData", cargaData_a, 8'h00);
        reset_a    = 1'b0;
        in_valid_a = 1'b0;
        step();
        chk("abort_no_accept", busy_a, 0);
        chk("abort_hold", cargaData_a, 8'h00);
        chk("abort_no_done", done_a, 0);
        frame_a(8'h81, 10'b0100000011, 1'b0, 8'h81);

        // BIT_CYCLES=1: one cycle per bit, shift on every DATA cycle.
        in_valid_b = 1'b1;
        in_data_b  = 8'h81;
        chk("b_pre_ready", in_ready_b, 1);
        step();
        chk("b_load_carga", carga_b, 1);
        chk("b_load_tx", tx_b, 1);
        in_valid_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            logic [9:0] pat_b;
            pat_b = 10'b0100000011;
            step();
            chk($sformatf("b_tx_%0d", i), tx_b, pat_b[9-i]);
            chk($sformatf("b_shift_%0d", i), shift_b, (i >= 1 && i <= 8));
            chk($sformatf("b_done_%0d", i), done_b, (i == 9));
            chk("b_busy", busy_b, 1);
        end
        step();
        chk("b_post_ready", in_ready_b, 1);
        chk("b_post_busy", busy_b, 0);
        chk("b_post_tx", tx_b, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
